btb_assoc: RTL

- Parametrised set-associative branch target buffer for the rv32i pipeline.
- Replaces the direct-mapped single-way BTB.
- Adds configurable sets and ways, tree pseudo-LRU replacement, and a 2-bit saturating direction counter per entry.
- Fetch looks up on one port; execute updates on an independent port every cycle.

---
 rtl/btb_assoc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with tree PLRU and 2-bit counters.
// Optional BTB_STATS_EN adds lookup/hit statistics counters.
module btb_assoc #(
  parameter  int SET_BITS = 5,
  parameter  int WAYS     = 2,
  localparam int TAG_W    = 30 - SET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        predict_taken,
  output logic        uncond,
  output logic [31:0] target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_is_jal
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits
`endif
);

  localparam int SETS = 1 << SET_BITS;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PB   = (WAYS > 1) ? WAYS - 1 : 1;

  logic             v_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [31:0]      tgt_q [SETS][WAYS];
  logic             unc_q [SETS][WAYS];
  logic [1:0]       ctr_q [SETS][WAYS];
  logic [PB-1:0]    plru_q[SETS];

  logic [SET_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit, inv_found, do_write;
  logic [WB-1:0]       l_way, u_way, inv_way, victim, w_way;
  logic [PB-1:0]       p, p_nxt;
  logic [1:0]          ctr_cur, ctr_nxt;
  logic                unused;

  assign l_idx  = lookup_pc[SET_BITS+1:2];
  assign l_tag  = lookup_pc[31:SET_BITS+2];
  assign u_idx  = update_pc[SET_BITS+1:2];
  assign u_tag  = update_pc[31:SET_BITS+2];
  assign unused = ^{lookup_pc[1:0], update_pc[1:0]};

  // Descending scans so the lowest matching/invalid way wins.
  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (v_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
        l_hit = 1'b1;
        l_way = WB'(w);
      end
    end
  end

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (v_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WB'(w);
      end
      if (!v_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
  end

  assign p = plru_q[u_idx];

  generate
    if (WAYS == 4) begin : g_w4
      assign victim = {p[0], p[0] ? p[2] : p[1]};
      always_comb begin
        p_nxt    = p;
        p_nxt[0] = ~w_way[1];
        if (w_way[1]) p_nxt[2] = ~w_way[0];
        else          p_nxt[1] = ~w_way[0];
      end
    end else if (WAYS == 2) begin : g_w2
      assign victim = p;
      assign p_nxt  = ~w_way;
    end else begin : g_w1
      assign victim = '0;
      assign p_nxt  = p;
    end
  endgenerate

  assign w_way    = u_hit ? u_way : (inv_found ? inv_way : victim);
  assign do_write = update_valid
                  & (u_hit | update_taken | update_is_jal);
  assign ctr_cur  = ctr_q[u_idx][w_way];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (!u_hit)                         ctr_nxt = 2'b10;
    else if (update_taken && ctr_cur != 2'b11)  ctr_nxt = ctr_cur + 2'd1;
    else if (!update_taken && ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          v_q[s][w]   <= 1'b0;
          ctr_q[s][w] <= 2'b01;
        end
      end
      hit           <= 1'b0;
      predict_taken <= 1'b0;
      uncond        <= 1'b0;
      target        <= '0;
    end else begin
      hit           <= lookup_valid & l_hit;
      uncond        <= lookup_valid & l_hit & unc_q[l_idx][l_way];
      predict_taken <= lookup_valid & l_hit
                     & (unc_q[l_idx][l_way] | ctr_q[l_idx][l_way][1]);
      target        <= (lookup_valid & l_hit) ? tgt_q[l_idx][l_way] : '0;
      if (do_write) begin
        v_q[u_idx][w_way]   <= 1'b1;
        tag_q[u_idx][w_way] <= u_tag;
        unc_q[u_idx][w_way] <= update_is_jal;
        ctr_q[u_idx][w_way] <= ctr_nxt;
        plru_q[u_idx]       <= p_nxt;
        if (!u_hit || update_taken)
          tgt_q[u_idx][w_way] <= update_target;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else begin
      if (lookup_valid)         stat_lookups <= stat_lookups + 32'd1;
      if (lookup_valid && l_hit) stat_hits   <= stat_hits + 32'd1;
    end
  end
`endif

endmodule
